// File: rtl/disk_track_ctrl.sv
// Whole-track NIB transfer sequencer between the SD block interface and the floppy track buffer.
// Flushes a dirty track before leaving it, loads the new one, and stalls the CPU meanwhile.
module disk_track_ctrl #(
  parameter int unsigned SECTORS = 13,
  parameter int unsigned TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               track_dirty,
  output logic               dirty_clr,
  input  logic               img_mounted,
  input  logic               img_valid,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  output logic [3:0]         track_sec,
  output logic               cpu_wait,
  output logic               busy
);

  localparam int unsigned PROD_W = 10;
  localparam int unsigned SEC_W  = 4;
  localparam int unsigned LBA_W  = 32;
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECTORS - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, LOAD, ACKWAIT} state_t;

  state_t             state, state_nx;
  logic [TRACK_W-1:0] cur_track, cur_track_nx;
  logic               loaded, loaded_nx;
  logic               mnt, mnt_nx;
  logic               old_ack;
  logic [LBA_W-1:0]   sd_lba_nx;
  logic               sd_rd_nx, sd_wr_nx;
  logic [SEC_W-1:0]   track_sec_nx;
  logic               cpu_wait_nx, dirty_clr_nx, busy_nx;

  logic mnt_eff, req, ack_rise, ack_fall;

  // First LBA of a track; product fits 10 bits for 13 sectors x 64 tracks.
  function automatic logic [LBA_W-1:0] track_base(input logic [TRACK_W-1:0] t);
    logic [PROD_W-1:0] p;
    p = PROD_W'(SECTORS) * PROD_W'(t);
    return LBA_W'(p);
  endfunction

  // A same-cycle mount counts, so a simultaneous mount and track step never flushes.
  assign mnt_eff  = mnt | img_mounted;
  assign req      = (track != cur_track) | mnt_eff;
  assign ack_rise = sd_ack & ~old_ack;
  assign ack_fall = ~sd_ack & old_ack;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ACKWAIT;
      cur_track <= '1;
      loaded    <= 1'b0;
      mnt       <= 1'b1;
      old_ack   <= 1'b0;
      sd_lba    <= '0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      track_sec <= '0;
      cpu_wait  <= 1'b0;
      dirty_clr <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_track <= cur_track_nx;
      loaded    <= loaded_nx;
      mnt       <= mnt_nx;
      old_ack   <= sd_ack;
      sd_lba    <= sd_lba_nx;
      sd_rd     <= sd_rd_nx;
      sd_wr     <= sd_wr_nx;
      track_sec <= track_sec_nx;
      cpu_wait  <= cpu_wait_nx;
      dirty_clr <= dirty_clr_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cur_track_nx = cur_track;
    loaded_nx    = loaded;
    mnt_nx       = mnt | img_mounted;
    sd_lba_nx    = sd_lba;
    sd_rd_nx     = sd_rd;
    sd_wr_nx     = sd_wr;
    track_sec_nx = track_sec;
    cpu_wait_nx  = cpu_wait;
    dirty_clr_nx = 1'b0;

    case (state)
      ACKWAIT: begin
        if (!sd_ack) state_nx = IDLE;
      end
      IDLE: begin
        // dirty_clr still high means the dirty flag just flushed has not cleared yet.
        if (req) begin
          if (loaded && track_dirty && !mnt_eff && !dirty_clr) begin
            sd_lba_nx    = track_base(cur_track);
            track_sec_nx = '0;
            sd_wr_nx     = 1'b1;
            cpu_wait_nx  = 1'b1;
            state_nx     = FLUSH;
          end else if (img_valid) begin
            cur_track_nx = track;
            sd_lba_nx    = track_base(track);
            track_sec_nx = '0;
            sd_rd_nx     = 1'b1;
            cpu_wait_nx  = 1'b1;
            mnt_nx       = 1'b0;
            state_nx     = LOAD;
          end else begin
            cur_track_nx = track;
            loaded_nx    = 1'b0;
            mnt_nx       = 1'b0;
            cpu_wait_nx  = 1'b0;
          end
        end
      end
      FLUSH, LOAD: begin
        if (ack_rise) begin
          sd_lba_nx = sd_lba + 32'd1;
          if (track_sec == LAST_SEC) begin
            sd_rd_nx = 1'b0;
            sd_wr_nx = 1'b0;
          end
        end
        // Request already dropped on this sector's rise: this fall ends the track.
        if (ack_fall) begin
          track_sec_nx = track_sec + 4'd1;
          if (!sd_rd && !sd_wr) begin
            state_nx = IDLE;
            if (state == FLUSH) begin
              dirty_clr_nx = 1'b1;
            end else begin
              loaded_nx   = 1'b1;
              cpu_wait_nx = 1'b0;
            end
          end
        end
      end
      default: state_nx = ACKWAIT;
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_disk_track_ctrl.sv
// Bench for disk_track_ctrl: a sector-level SD host model plus table-driven track moves.
module tb_disk_track_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        track_dirty;
  logic        dirty_clr;
  logic        img_mounted;
  logic        img_valid;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [3:0]  track_sec;
  logic        cpu_wait;
  logic        busy;

  disk_track_ctrl #(.SECTORS(13), .TRACK_W(6)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .track       (track),
    .track_dirty (track_dirty),
    .dirty_clr   (dirty_clr),
    .img_mounted (img_mounted),
    .img_valid   (img_valid),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .track_sec   (track_sec),
    .cpu_wait    (cpu_wait),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        wr;
    logic [31:0] lba;
    logic [3:0]  sec;
  } xfer_t;

  typedef struct {
    logic [5:0] trk;
    logic       dirty;
    logic       valid;
    logic       mount;
    int         exp_req;
    int         exp_nwr;
    int         exp_wr_lba;
    int         exp_nrd;
    int         exp_rd_lba;
    int         exp_dclr;
    int         exp_falls;
    int         exp_loaded;
  } vec_t;

  xfer_t log_q[$];
  int    dclr_cnt = 0;
  int    cw_falls = 0;
  int    total    = 0;
  int    passed   = 0;

  // Host: one sector per request; LBA and sector index are sampled before ack rises.
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) begin
        log_q.push_back('{wr: sd_wr, lba: sd_lba, sec: track_sec});
        repeat (2) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (6) @(negedge clk_sys);
        sd_ack = 1'b0;
        repeat (2) @(negedge clk_sys);
      end
    end
  end

  initial begin
    logic prev_cw;
    prev_cw = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (dirty_clr === 1'b1) dclr_cnt++;
      if (prev_cw === 1'b1 && cpu_wait === 1'b0) cw_falls++;
      prev_cw = cpu_wait;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic wait_idle(input string name);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 8 && n < 3000) begin
      @(negedge clk_sys);
      n++;
      if (!busy && !sd_rd && !sd_wr && !sd_ack && !cpu_wait) quiet++;
      else quiet = 0;
    end
    chk({name, "_settle"}, (quiet >= 8) ? 1 : 0, 1);
  endtask

  // 1 when n consecutive log entries from idx are the given direction, LBA first+k, sector k.
  function automatic int seq_ok(input int idx, input int n, input int first, input logic wr);
    if (idx + n > log_q.size()) return 0;
    for (int k = 0; k < n; k++) begin
      if (log_q[idx+k].wr !== wr || log_q[idx+k].lba !== 32'(first + k) ||
          log_q[idx+k].sec !== 4'(k))
        return 0;
    end
    return 1;
  endfunction

  task automatic count_dirs(input int base, output int nwr, output int nrd);
    nwr = 0;
    nrd = 0;
    for (int j = base; j < log_q.size(); j++) begin
      if (log_q[j].wr) nwr++;
      else nrd++;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int base, dclr0, falls0, nwr, nrd, n;
    logic bad;

    vecs[0] = '{6'd5,  1'b0, 1'b1, 1'b0, 1, 0,  0,   13, 65,  0, 1, 1};
    vecs[1] = '{6'd6,  1'b1, 1'b1, 1'b0, 1, 13, 65,  13, 78,  1, 1, 1};
    vecs[2] = '{6'd6,  1'b1, 1'b1, 1'b1, 1, 0,  0,   13, 78,  0, 1, 1};
    vecs[3] = '{6'd63, 1'b0, 1'b1, 1'b0, 1, 0,  0,   13, 819, 0, 1, 1};
    vecs[4] = '{6'd0,  1'b1, 1'b1, 1'b0, 1, 13, 819, 13, 0,   1, 1, 1};
    vecs[5] = '{6'd10, 1'b0, 1'b0, 1'b0, 0, 0,  0,   0,  0,   0, 0, 0};
    vecs[6] = '{6'd10, 1'b0, 1'b1, 1'b1, 1, 0,  0,   13, 130, 0, 1, 1};
    vecs[7] = '{6'd3,  1'b1, 1'b1, 1'b1, 1, 0,  0,   13, 39,  0, 1, 1};

    reset = 1'b1;
    track = 6'd0;
    track_dirty = 1'b0;
    img_mounted = 1'b0;
    img_valid = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_sd_rd", 32'(sd_rd), 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_cpu_wait", 32'(cpu_wait), 0);
    chk("rst_dirty_clr", 32'(dirty_clr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sd_lba", 32'(sd_lba), 0);
    chk("rst_track_sec", 32'(track_sec), 0);

    // Power-up load of track 0, forced by the all-ones cur_track and sticky mount.
    base = log_q.size();
    falls0 = cw_falls;
    dclr0 = dclr_cnt;
    reset = 1'b0;
    wait_idle("boot");
    count_dirs(base, nwr, nrd);
    chk("boot_nwr", nwr, 0);
    chk("boot_nrd", nrd, 13);
    chk("boot_rd_seq", seq_ok(base, 13, 0, 1'b0), 1);
    chk("boot_cpu_falls", cw_falls - falls0, 1);
    chk("boot_dclr", dclr_cnt - dclr0, 0);
    chk("boot_loaded", 32'(dut.loaded), 1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      base = log_q.size();
      dclr0 = dclr_cnt;
      falls0 = cw_falls;
      track = vecs[i].trk;
      track_dirty = vecs[i].dirty;
      img_valid = vecs[i].valid;
      img_mounted = vecs[i].mount;
      @(negedge clk_sys);
      img_mounted = 1'b0;
      chk($sformatf("v%0d_req_latency", i), (sd_rd || sd_wr) ? 1 : 0, vecs[i].exp_req);
      chk($sformatf("v%0d_cpu_wait_latency", i), 32'(cpu_wait), vecs[i].exp_req);
      wait_idle($sformatf("v%0d", i));
      count_dirs(base, nwr, nrd);
      chk($sformatf("v%0d_nwr", i), nwr, vecs[i].exp_nwr);
      chk($sformatf("v%0d_nrd", i), nrd, vecs[i].exp_nrd);
      if (vecs[i].exp_nwr > 0)
        chk($sformatf("v%0d_wr_seq", i), seq_ok(base, 13, vecs[i].exp_wr_lba, 1'b1), 1);
      if (vecs[i].exp_nrd > 0)
        chk($sformatf("v%0d_rd_seq", i),
            seq_ok(base + vecs[i].exp_nwr, 13, vecs[i].exp_rd_lba, 1'b0), 1);
      chk($sformatf("v%0d_dirty_clr", i), dclr_cnt - dclr0, vecs[i].exp_dclr);
      chk($sformatf("v%0d_cpu_falls", i), cw_falls - falls0, vecs[i].exp_falls);
      chk($sformatf("v%0d_loaded", i), 32'(dut.loaded), vecs[i].exp_loaded);
      track_dirty = 1'b0;
    end

    // Mount while loading sector 4 of track 4: finish, then reload track 4 without a flush.
    @(negedge clk_sys);
    base = log_q.size();
    dclr0 = dclr_cnt;
    falls0 = cw_falls;
    track = 6'd4;
    n = 0;
    while (log_q.size() < base + 5 && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    chk("mnt_reach_sec4", (log_q.size() >= base + 5) ? 1 : 0, 1);
    track_dirty = 1'b1;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    wait_idle("mnt");
    count_dirs(base, nwr, nrd);
    chk("mnt_nwr", nwr, 0);
    chk("mnt_nrd", nrd, 26);
    chk("mnt_first_seq", seq_ok(base, 13, 52, 1'b0), 1);
    chk("mnt_reload_seq", seq_ok(base + 13, 13, 52, 1'b0), 1);
    chk("mnt_dirty_clr", dclr_cnt - dclr0, 0);
    chk("mnt_cpu_falls", cw_falls - falls0, 2);
    track_dirty = 1'b0;

    // Reset during the third FLUSH sector with ack high.
    @(negedge clk_sys);
    base = log_q.size();
    dclr0 = dclr_cnt;
    track = 6'd9;
    track_dirty = 1'b1;
    n = 0;
    while (!(log_q.size() >= base + 3 && sd_ack) && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    chk("rstx_reach_ack", (log_q.size() >= base + 3 && sd_ack) ? 1 : 0, 1);
    chk("rstx_flushing", 32'(sd_wr), 1);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    chk("rstx_sd_wr", 32'(sd_wr), 0);
    chk("rstx_dirty_clr", 32'(dirty_clr), 0);
    chk("rstx_cpu_wait", 32'(cpu_wait), 0);
    bad = 1'b0;
    n = 0;
    while (sd_ack && n < 50) begin
      if (sd_rd || sd_wr) bad = 1'b1;
      @(negedge clk_sys);
      n++;
    end
    chk("rstx_quiet_while_ack", 32'(bad), 0);
    base = log_q.size();
    wait_idle("rstx");
    count_dirs(base, nwr, nrd);
    chk("rstx_nwr", nwr, 0);
    chk("rstx_nrd", nrd, 13);
    chk("rstx_rd_seq", seq_ok(base, 13, 117, 1'b0), 1);
    chk("rstx_dclr_total", dclr_cnt - dclr0, 0);
    chk("rstx_loaded", 32'(dut.loaded), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/disk_track_ctrl.md
# disk_track_ctrl

Sequences whole-track transfers between the HPS SD block interface and the floppy track buffer RAM for NIB images. It watches the drive's current track, writes a dirty track back to the image before leaving it, and loads the new track 13 sectors at a time. It stalls the CPU for the duration of each transfer and drives the sector index that forms the upper track-buffer RAM address bits. It sits in `emu` between `hps_io` and `apple2_top`, replacing the ad-hoc loader process there.

## Interface

Parameters:
- SECTORS, 13, 512-byte SD sectors per NIB track (6656 bytes)
- TRACK_W, 6, width of the track number

Ports:
- clk_sys  in  1  system clock; the single clock
- reset  in  1  synchronous, active-high reset
- track  in  TRACK_W  track currently under the head, from the disk core
- track_dirty  in  1  level; track buffer modified since the last load or flush
- dirty_clr  out  1  one-cycle pulse when a flush completes
- img_mounted  in  1  one-cycle pulse on image mount or change
- img_valid  in  1  image present; `img_size != 0`
- sd_lba  out  32  SD sector address
- sd_rd  out  1  read request, level
- sd_wr  out  1  write request, level
- sd_ack  in  1  host acknowledge; high while a sector transfers
- track_sec  out  4  sector index within the track; upper bits of the track RAM address
- cpu_wait  out  1  stall CPU while the track buffer is inconsistent
- busy  out  1  state ≠ IDLE

## Operation

States: IDLE, FLUSH, LOAD, ACKWAIT.

Registers:
- cur_track (TRACK_W): track held in the buffer.
- loaded (1): buffer holds valid image data.
- mnt (1): sticky; set by img_mounted, cleared when the resulting LOAD starts.

IDLE: a request exists if (`track != cur_track` or `mnt`).
- Request with `loaded & track_dirty & ~mnt`:
  - latch `base = SECTORS*cur_track`
  - `sd_lba <= base`, `track_sec <= 0`, `sd_wr <= 1`, `cpu_wait <= 1`
  - go to FLUSH
- Request otherwise, with img_valid:
  - `cur_track <= track`, `sd_lba <= SECTORS*track`, `track_sec <= 0`, `sd_rd <= 1`, `cpu_wait <= 1`, clear mnt
  - go to LOAD
- Request otherwise, without img_valid:
  - `cur_track <= track`, `loaded <= 0`, clear mnt
  - stay in IDLE
- A dirty buffer is never written to a newly mounted image: mnt suppresses FLUSH.

FLUSH / LOAD, per sector, driven by sd_ack edges (`old_ack` is registered):
- Rising edge:
  - `sd_lba <= sd_lba + 1`
  - if `track_sec == SECTORS-1`, drop the request (sd_rd or sd_wr) in the same cycle
- Falling edge:
  - `track_sec <= track_sec + 1`
  - if the request is already dropped: FLUSH pulses dirty_clr and returns to IDLE, which then issues the LOAD; LOAD sets `loaded <= 1`, clears cpu_wait and goes to IDLE.
- cpu_wait stays high from the first request until the last falling ack of LOAD. Between FLUSH and LOAD it is not released.

Mount during FLUSH or LOAD:
- mnt is set.
- The current transfer runs to completion.
- IDLE then reloads from the new image.

Arithmetic:
- `SECTORS*track` is computed in 10 bits; max 13*63 = 819.
- It is zero-extended to 32 bits.
- sd_lba increments without saturation.

ACKWAIT (entered from reset):
- Holds until `sd_ack == 0`.
- Then goes to IDLE.

## Timing

Reset values:
- sd_rd, sd_wr, cpu_wait, dirty_clr, busy: 0
- sd_lba: 0
- track_sec: 0
- cur_track: all-ones, which forces a load after reset when track = 0
- loaded: 0
- mnt: 1
- state: ACKWAIT

Reset mid-transfer:
- Requests drop on the next edge.
- No dirty_clr pulse is produced.
- A dirty track is lost (accepted).

Latency and handshake:
- Request detected in IDLE at cycle N → sd_rd/sd_wr and cpu_wait high at N+1.
- Edges are detected one cycle after sd_ack changes.
- sd_lba updates while sd_ack is high and is stable before the next request is sampled. The host samples a new LBA only after ack falls.
- track_sec changes only on falling ack, so it is stable across every sd_buff_wr in a sector.
- track changing during a transfer is ignored until IDLE.
- Simultaneous img_mounted and track change in IDLE: a single LOAD of the new track, no FLUSH.

## Test plan

- Reset release, img_valid=1, track=0, sd_ack=0 → ACKWAIT→IDLE; LOAD issues sd_lba=0..12, track_sec 0..12; cpu_wait falls after the 13th ack falls; loaded=1.
- track 0→5 with track_dirty=0 → sd_rd only, first sd_lba=65, last 77; sd_wr never asserted.
- track 5→6 with track_dirty=1 → sd_wr with sd_lba 65..77, dirty_clr one pulse, then sd_rd 78..90; cpu_wait continuously high across both.
- img_mounted pulse during a dirty LOAD on sector 4 → sector transfer completes, then a reload of the current track from LBA 13*track with no sd_wr.
- img_valid=0, track change → no sd_rd/sd_wr, cpu_wait stays 0, loaded=0; subsequent mount with img_valid=1 → load occurs.
- Reset asserted while sd_ack=1 mid-FLUSH → sd_wr=0 next cycle, no dirty_clr; controller waits for sd_ack=0 before issuing a new LOAD.
